alu_ctrl_seq: RTL and testbench
===============================

Name: alu_ctrl_seq

Overview:
- Sequenced ALU control unit for the MIPS-subset datapath.
- Decodes the R-type funct field into ALU op, shifter select, multiplier start and result-mux select.
- Tracks a multi-cycle MULTU with an internal counter and stalls HI/LO reads (MFHI/MFLO) and back-to-back MULTU through a valid/ready handshake.
- Sits between the instruction register and the ALU / shifter / multiplier / result-mux bank.

Parameters:
- MUL_CYCLES, 32, cycles the multiplier needs per MULTU. Legal range 1..63.
- CNT_W, 6, busy-counter width. Must satisfy 2^CNT_W > MUL_CYCLES.
- ENABLE_MUL, 1. When 0, MULTU/MFHI/MFLO decode as illegal, no counter activity, and mul_start is tied to 0.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  funct presented this cycle
- funct  in  6  R-type function field
- in_ready  out  1  unit can accept funct (combinational)
- out_valid  out  1  decoded outputs valid this cycle (registered pulse)
- alu_op  out  3  ALU operation code
- mux_sel  out  2  result select: 00 ALU, 01 shifter, 10 HI, 11 LO
- mul_start  out  1  one-cycle start pulse to multiplier
- wb_en  out  1  register-file write enable for this op
- illegal  out  1  undecodable op, or HI/LO read before any MULTU completed
- busy  out  1  multiplier in progress
- hilo_valid  out  1  HI/LO hold a completed product

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous, active-low.
- Reset: rst_n low at a rising edge forces state IDLE, counter 0, and all registered outputs to 0 (out_valid, alu_op, mux_sel, mul_start, wb_en, illegal, busy, hilo_valid). Reset dominates in_valid. A reset during MUL_BUSY aborts the multiply; hilo_valid returns to 0.
- Accept: handshake completes at an edge where in_valid && in_ready. Decoded outputs are registered: they appear after that edge and last exactly one cycle with out_valid=1. With no accept, out_valid, mul_start, wb_en and illegal are 0; alu_op and mux_sel hold their last values.
- Decode, registered on accept:
  - AND 100100: alu_op 000, mux 00, wb 1
  - OR 100101: alu_op 001, mux 00, wb 1
  - ADD 100000: alu_op 010, mux 00, wb 1
  - SUB 100010: alu_op 110, mux 00, wb 1
  - SLT 101010: alu_op 111, mux 00, wb 1
  - SLL 000000: alu_op 000, mux 01, wb 1
  - MULTU 011001: mul_start 1, mux 00, wb 0
  - MFHI 010000: mux 10, wb 1
  - MFLO 010010: mux 11, wb 1
  - Any other funct: illegal 1, wb 0, alu_op 000, mux 00.
  - MFHI/MFLO with hilo_valid=0: illegal 1, wb 0.
- State machine:
  - IDLE -> MUL_BUSY on accepted MULTU. The counter loads MUL_CYCLES at that edge.
  - In MUL_BUSY, the counter decrements every edge. At the edge where counter==1: state goes to IDLE, counter goes to 0, hilo_valid goes to 1 (sticky until reset).
  - busy = (state==MUL_BUSY), registered.
- in_ready = !(state==MUL_BUSY && funct ∈ {MULTU, MFHI, MFLO}).
  - ALU and shift ops are accepted while busy; they overlap the multiply.
  - in_ready is 1 for all funct values when ENABLE_MUL=0.
- Timing: a MULTU accepted at edge k holds busy for edges k..k+MUL_CYCLES-1. A stalled MFHI/MFLO/MULTU is accepted no earlier than edge k+MUL_CYCLES+1.
- Back-to-back MULTU is legal once IDLE. It reloads the counter; hilo_valid stays 1.

Test Plan:
- Reset: rst_n=0 for 2 cycles with in_valid=1, funct=ADD -> all outputs 0, in_ready=1. Release, then ADD accepted -> next cycle out_valid=1, alu_op=010, mux_sel=00, wb_en=1.
- Decode sweep: each of the 9 legal funct codes plus 111111, one per cycle -> table values each following cycle. 111111 gives illegal=1, wb_en=0.
- MUL_CYCLES=4: MULTU at edge 1; MFHI held valid from cycle 2 -> mul_start pulse after edge 1; busy high edges 1..4; in_ready low until after edge 5; MFHI accepted edge 6 with mux_sel=10, wb_en=1, illegal=0.
- Overlap: during the MULTU busy window issue ADD, SLL, SUB -> each accepted in consecutive cycles with correct outputs; busy unaffected.
- Stale read: MFLO after reset with no prior MULTU -> out_valid=1, illegal=1, wb_en=0.
- Reset mid-op: MULTU, then rst_n=0 at the 2nd busy cycle -> busy=0 and hilo_valid=0 next cycle; a following MFHI is flagged illegal.

Source files
------------

// File: rtl/alu_ctrl_if.sv
// Handshake and decoded-output bundle between the instruction register side
// and the ALU control sequencer.
interface alu_ctrl_if;
  logic       in_valid;
  logic [5:0] funct;
  logic       in_ready;
  logic       out_valid;
  logic [2:0] alu_op;
  logic [1:0] mux_sel;
  logic       mul_start;
  logic       wb_en;
  logic       illegal;
  logic       busy;
  logic       hilo_valid;

  modport master (
    output in_valid, funct,
    input  in_ready, out_valid, alu_op, mux_sel, mul_start, wb_en, illegal,
           busy, hilo_valid
  );

  modport slave (
    input  in_valid, funct,
    output in_ready, out_valid, alu_op, mux_sel, mul_start, wb_en, illegal,
           busy, hilo_valid
  );
endinterface

// File: rtl/alu_ctrl_seq.sv
// Sequenced ALU control unit: decodes R-type funct, tracks a multi-cycle MULTU
// and stalls HI/LO reads and back-to-back MULTU until the product is ready.
module alu_ctrl_seq #(
  parameter int MUL_CYCLES = 32,
  parameter int CNT_W      = 6,
  parameter bit ENABLE_MUL = 1'b1
) (
  input logic     clk,
  input logic     rst_n,
  alu_ctrl_if.slave bus
);

  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  typedef enum logic {IDLE, MUL_BUSY} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hilo_q, hilo_d;

  logic       is_mulop;
  logic       accept;
  logic [2:0] dec_alu;
  logic [1:0] dec_mux;
  logic       dec_wb, dec_mul, dec_ill;

  // Ops that touch the multiplier or HI/LO must wait for an in-flight multiply.
  assign is_mulop = ENABLE_MUL && (bus.funct inside {F_MULTU, F_MFHI, F_MFLO});
  assign bus.in_ready   = !(state_q == MUL_BUSY && is_mulop);
  assign accept         = bus.in_valid && bus.in_ready;
  assign bus.hilo_valid = hilo_q;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    dec_alu = 3'b000;
    dec_mux = 2'b00;
    dec_wb  = 1'b0;
    dec_mul = 1'b0;
    dec_ill = 1'b0;
    case (bus.funct)
      F_AND:   dec_wb = 1'b1;
      F_OR:    begin dec_alu = 3'b001; dec_wb = 1'b1; end
      F_ADD:   begin dec_alu = 3'b010; dec_wb = 1'b1; end
      F_SUB:   begin dec_alu = 3'b110; dec_wb = 1'b1; end
      F_SLT:   begin dec_alu = 3'b111; dec_wb = 1'b1; end
      F_SLL:   begin dec_mux = 2'b01;  dec_wb = 1'b1; end
      F_MULTU: if (ENABLE_MUL) dec_mul = 1'b1; else dec_ill = 1'b1;
      // Reading HI/LO before any product exists is flagged rather than stalled.
      F_MFHI:  if (ENABLE_MUL && hilo_q) begin dec_mux = 2'b10; dec_wb = 1'b1; end
               else dec_ill = 1'b1;
      F_MFLO:  if (ENABLE_MUL && hilo_q) begin dec_mux = 2'b11; dec_wb = 1'b1; end
               else dec_ill = 1'b1;
      default: dec_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hilo_d  = hilo_q;
    case (state_q)
      IDLE: begin
        if (accept && dec_mul) begin
          state_d = MUL_BUSY;
          cnt_d   = CNT_W'(MUL_CYCLES);
        end
      end
      MUL_BUSY: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          hilo_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      hilo_q        <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.alu_op    <= 3'b000;
      bus.mux_sel   <= 2'b00;
      bus.mul_start <= 1'b0;
      bus.wb_en     <= 1'b0;
      bus.illegal   <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hilo_q        <= hilo_d;
      bus.out_valid <= accept;
      bus.mul_start <= accept && dec_mul;
      bus.wb_en     <= accept && dec_wb;
      bus.illegal   <= accept && dec_ill;
      bus.busy      <= (state_d == MUL_BUSY);
      if (accept) begin
        bus.alu_op  <= dec_alu;
        bus.mux_sel <= dec_mux;
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: directed plan plus randomized traffic
// compared every cycle against an edge-counting behavioural model.
module tb_alu_ctrl_seq;

  localparam int MC = 4;

  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_BAD   = 6'b111111;

  localparam logic [5:0] SWEEP [10] = '{F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SLL,
                                        F_MFHI, F_MFLO, F_MULTU, F_BAD};

  typedef struct packed {
    logic [2:0] alu;
    logic [1:0] mux;
    logic       mul;
    logic       wb;
    logic       ill;
  } dec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_ctrl_if bus ();

  alu_ctrl_seq #(.MUL_CYCLES(MC), .CNT_W(6), .ENABLE_MUL(1'b1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic dec_t spec_decode(input logic [5:0] f, input bit hv);
    dec_t d;
    d = '0;
    case (f)
      F_AND:   d.wb = 1'b1;
      F_OR:    begin d.alu = 3'b001; d.wb = 1'b1; end
      F_ADD:   begin d.alu = 3'b010; d.wb = 1'b1; end
      F_SUB:   begin d.alu = 3'b110; d.wb = 1'b1; end
      F_SLT:   begin d.alu = 3'b111; d.wb = 1'b1; end
      F_SLL:   begin d.mux = 2'b01;  d.wb = 1'b1; end
      F_MULTU: d.mul = 1'b1;
      F_MFHI:  if (hv) begin d.mux = 2'b10; d.wb = 1'b1; end else d.ill = 1'b1;
      F_MFLO:  if (hv) begin d.mux = 2'b11; d.wb = 1'b1; end else d.ill = 1'b1;
      default: d.ill = 1'b1;
    endcase
    return d;
  endfunction

  function automatic bit is_mulop(input logic [5:0] f);
    return (f == F_MULTU) || (f == F_MFHI) || (f == F_MFLO);
  endfunction

  // Model: a MULTU accepted at edge k keeps the unit busy after edges
  // k..k+MC-1 and makes HI/LO valid from edge k+MC on.
  longint     edge_n = 0;
  longint     busy_end = -1;
  bit         m_hilo = 1'b0;
  bit         m_acc = 1'b0;
  bit         exp_ov, exp_ms, exp_wb, exp_ill, exp_busy;
  logic [2:0] exp_alu = 3'b000;
  logic [1:0] exp_mux = 2'b00;

  longint dut_mfhi_edge = -1;
  int     dut_busy_cnt = 0;
  bit     count_busy = 1'b0;

  always @(posedge clk) begin
    bit   busy_before;
    bit   rdy;
    dec_t d;
    edge_n++;
    if (!rst_n) begin
      busy_end = -1;
      m_hilo   = 1'b0;
      m_acc    = 1'b0;
      exp_ov   = 1'b0;
      exp_ms   = 1'b0;
      exp_wb   = 1'b0;
      exp_ill  = 1'b0;
      exp_alu  = 3'b000;
      exp_mux  = 2'b00;
    end else begin
      busy_before = (edge_n - 1 <= busy_end);
      rdy         = !(busy_before && is_mulop(bus.funct));
      m_acc       = bus.in_valid && rdy;
      d           = spec_decode(bus.funct, m_hilo);
      if (busy_end >= 0 && edge_n == busy_end + 1) m_hilo = 1'b1;
      exp_ov  = m_acc;
      exp_ms  = m_acc && d.mul;
      exp_wb  = m_acc && d.wb;
      exp_ill = m_acc && d.ill;
      if (m_acc) begin
        exp_alu = d.alu;
        exp_mux = d.mux;
      end
      if (m_acc && d.mul) busy_end = edge_n + MC - 1;
    end
    exp_busy = (edge_n <= busy_end);
    #1;
    check("out_valid",  32'(bus.out_valid),  32'(exp_ov));
    check("mul_start",  32'(bus.mul_start),  32'(exp_ms));
    check("wb_en",      32'(bus.wb_en),      32'(exp_wb));
    check("illegal",    32'(bus.illegal),    32'(exp_ill));
    check("alu_op",     32'(bus.alu_op),     32'(exp_alu));
    check("mux_sel",    32'(bus.mux_sel),    32'(exp_mux));
    check("busy",       32'(bus.busy),       32'(exp_busy));
    check("hilo_valid", 32'(bus.hilo_valid), 32'(m_hilo));
    check("in_ready",   32'(bus.in_ready),   32'(!(exp_busy && is_mulop(bus.funct))));
    if (bus.out_valid && bus.mux_sel == 2'b10 && !bus.illegal) dut_mfhi_edge = edge_n;
    if (count_busy && bus.busy) dut_busy_cnt++;
  end

  task automatic drive(input logic v, input logic [5:0] f);
    bus.in_valid = v;
    bus.funct    = f;
    @(negedge clk);
  endtask

  initial begin
    longint multu_edge;
    bus.in_valid = 1'b1;
    bus.funct    = F_ADD;
    rst_n        = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_wb_en",     32'(bus.wb_en),     32'd0);
    check("rst_alu_op",    32'(bus.alu_op),    32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);

    rst_n = 1'b1;
    drive(1'b1, F_ADD);
    check("add_out_valid", 32'(bus.out_valid), 32'd1);
    check("add_alu_op",    32'(bus.alu_op),    32'h2);
    check("add_mux_sel",   32'(bus.mux_sel),   32'd0);
    check("add_wb_en",     32'(bus.wb_en),     32'd1);

    drive(1'b1, F_MFLO);
    check("stale_out_valid", 32'(bus.out_valid), 32'd1);
    check("stale_illegal",   32'(bus.illegal),   32'd1);
    check("stale_wb_en",     32'(bus.wb_en),     32'd0);

    for (int i = 0; i < 10; i++) drive(1'b1, SWEEP[i]);
    check("bad_illegal", 32'(bus.illegal), 32'd1);
    check("bad_wb_en",   32'(bus.wb_en),   32'd0);
    repeat (8) drive(1'b0, F_AND);

    count_busy = 1'b1;
    drive(1'b1, F_MULTU);
    multu_edge = edge_n;
    check("multu_start", 32'(bus.mul_start), 32'd1);
    bus.funct = F_MFHI;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_acc) break;
    end
    check("mfhi_accepted", 32'(m_acc),        32'd1);
    check("mfhi_mux_sel",  32'(bus.mux_sel),  32'h2);
    check("mfhi_wb_en",    32'(bus.wb_en),    32'd1);
    check("mfhi_illegal",  32'(bus.illegal),  32'd0);
    check("mfhi_latency",  32'(dut_mfhi_edge - multu_edge), 32'(MC + 1));
    repeat (2) drive(1'b0, F_AND);
    count_busy = 1'b0;
    check("busy_cycles", 32'(dut_busy_cnt), 32'(MC));

    drive(1'b1, F_MULTU);
    drive(1'b1, F_ADD);
    check("ovl_add_busy", 32'(bus.busy),   32'd1);
    check("ovl_add_op",   32'(bus.alu_op), 32'h2);
    drive(1'b1, F_SLL);
    check("ovl_sll_mux",  32'(bus.mux_sel), 32'd1);
    drive(1'b1, F_SUB);
    check("ovl_sub_op",   32'(bus.alu_op), 32'h6);
    repeat (6) drive(1'b0, F_AND);

    drive(1'b1, F_MULTU);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(bus.busy),       32'd0);
    check("abort_hilo", 32'(bus.hilo_valid), 32'd0);
    rst_n = 1'b1;
    drive(1'b1, F_MFHI);
    check("abort_mfhi_illegal", 32'(bus.illegal), 32'd1);
    check("abort_mfhi_wb_en",   32'(bus.wb_en),   32'd0);
    drive(1'b0, F_AND);

    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 4) == 0) drive($urandom_range(0, 3) != 0, 6'($urandom));
      else drive($urandom_range(0, 3) != 0, SWEEP[$urandom_range(0, 8)]);
    end
    rst_n = 1'b1;
    repeat (10) drive(1'b0, F_AND);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
